// File: rtl/alu_seq_16bit_pkg.sv
// rtl/alu_seq_16bit_pkg.sv - opcodes, FSM states and shift modes for the sequential ALU
package alu_seq_16bit_pkg;

  localparam int ALU_WIDTH   = 16;
  localparam int ALU_SHAMT_W = 4;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_BSEL = 3'b011,
    OP_SHL  = 3'b100,
    OP_SHR  = 3'b101,
    OP_ROL  = 3'b110,
    OP_ILL  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SM_SHL  = 2'd0,
    SM_SHR  = 2'd1,
    SM_ROL  = 2'd2,
    SM_PASS = 2'd3
  } shift_mode_e;

  // Ops 100..110 are the iterative ones; everything else completes in one cycle.
  function automatic logic is_shift_op(input logic [2:0] op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL);
  endfunction

  function automatic shift_mode_e shift_mode_of(input logic [2:0] op);
    case (op)
      OP_SHL:  return SM_SHL;
      OP_SHR:  return SM_SHR;
      OP_ROL:  return SM_ROL;
      default: return SM_PASS;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_16bit_gates.sv
// rtl/alu_seq_16bit_gates.sv - 16-bit gate library (AND/OR/XOR and 16:1 bit mux)
module AND_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] out
);
  assign out = a & b;
endmodule

module OR_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] out
);
  assign out = a | b;
endmodule

module XOR_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] out
);
  assign out = a ^ b;
endmodule

// Selects one bit of nums by the 4-bit index op.
module MUX_16bit (
  input  logic [15:0] nums,
  input  logic [3:0]  op,
  output logic        out
);
  assign out = nums[op];
endmodule

// File: rtl/alu_seq_16bit_shift.sv
// rtl/alu_seq_16bit_shift.sv - combinational one-bit shift/rotate step
module shift_step_16bit
  import alu_seq_16bit_pkg::*;
(
  input  logic [15:0] din,
  input  logic [1:0]  mode,
  output logic [15:0] dout
);

  // One step per call; the FSM iterates this block b[3:0] times.
  always_comb begin
    dout = din;
    case (mode)
      SM_SHL:  dout = {din[14:0], 1'b0};
      SM_SHR:  dout = {1'b0, din[15:1]};
      SM_ROL:  dout = {din[14:0], din[15]};
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/alu_seq_16bit.sv
// rtl/alu_seq_16bit.sv - sequential 16-bit ALU stage with iterative shifter and handshakes
module alu_seq_16bit
  import alu_seq_16bit_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               err
);

  generate
    if (WIDTH != 16 || SHAMT_W != 4) begin : g_bad_width
      $error("alu_seq_16bit supports only WIDTH=16, SHAMT_W=4");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  shift_mode_e        mode_q, mode_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               err_q, err_d;

  logic [WIDTH-1:0]   and_w, or_w, xor_w, step_w, logic_res;
  logic               bsel_w;

  // Single-cycle operations come straight from the gate library on the live inputs;
  // they are only consumed on the accept edge.
  AND_16bit u_and (.a(a), .b(b), .out(and_w));
  OR_16bit  u_or  (.a(a), .b(b), .out(or_w));
  XOR_16bit u_xor (.a(a), .b(b), .out(xor_w));
  MUX_16bit u_mux (.nums(a), .op(b[SHAMT_W-1:0]), .out(bsel_w));

  shift_step_16bit u_step (.din(work_q), .mode(mode_q), .dout(step_w));

  // Result of the non-iterative opcodes; illegal opcode yields zero.
  always_comb begin
    logic_res = '0;
    case (op_e'(op))
      OP_AND:  logic_res = and_w;
      OP_OR:   logic_res = or_w;
      OP_XOR:  logic_res = xor_w;
      OP_BSEL: logic_res = {{(WIDTH-1){1'b0}}, bsel_w};
      default: logic_res = '0;
    endcase
  end

  // Next-state logic: accept in IDLE, iterate in SHIFT, hold until handshake in DONE.
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          err_d = (op == OP_ILL);
          if (is_shift_op(op)) begin
            work_d = a;
            cnt_d  = b[SHAMT_W-1:0];
            mode_d = shift_mode_of(op);
            if (b[SHAMT_W-1:0] == '0) begin
              result_d = a;
              zero_d   = (a == '0);
              state_d  = ST_DONE;
            end else begin
              state_d  = ST_SHIFT;
            end
          end else begin
            result_d = logic_res;
            zero_d   = (logic_res == '0);
            state_d  = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        work_d = step_w;
        cnt_d  = cnt_q - SHAMT_W'(1);
        // Last step: the value leaving the shifter is the final result.
        if (cnt_q == SHAMT_W'(1)) begin
          result_d = step_w;
          zero_d   = (step_w == '0);
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight or pending result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      work_q   <= '0;
      cnt_q    <= '0;
      mode_q   <= SM_PASS;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_seq_16bit.sv
// tb/tb_alu_seq_16bit.sv - self-checking bench for alu_seq_16bit
module tb_alu_seq_16bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [15:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        zero;
  logic        err;

  int checks = 0;
  int errors = 0;

  alu_seq_16bit dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        z;
    logic        e;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  logic [15:0] got_res;
  logic        got_z, got_e;
  int          got_lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: result, flags and latency straight from the opcode definitions.
  task automatic model(input logic [2:0] mop, input logic [15:0] ma, input logic [15:0] mb,
                       output logic [15:0] r, output logic z, output logic e, output int lat);
    int n;
    logic [31:0] dbl;
    n   = int'(mb[3:0]);
    e   = 1'b0;
    lat = 1;
    case (mop)
      3'd0: r = ma & mb;
      3'd1: r = ma | mb;
      3'd2: r = ma ^ mb;
      3'd3: r = 16'((ma >> n) & 16'd1);
      3'd4: begin r = 16'(ma << n); lat = 1 + n; end
      3'd5: begin r = ma >> n;      lat = 1 + n; end
      3'd6: begin dbl = {ma, ma} << n; r = dbl[31:16]; lat = 1 + n; end
      default: begin r = 16'd0; e = 1'b1; end
    endcase
    z = (r == 16'd0);
  endtask

  // Issue one op and wait (bounded) for out_valid; leaves the result in got_*.
  task automatic do_op(input logic [2:0] top, input logic [15:0] ta, input logic [15:0] tb);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1; op = top; a = ta; b = tb;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 3'($urandom); a = 16'($urandom); b = 16'($urandom);
    got_lat = 1;
    while (!out_valid && got_lat < 40) begin
      @(posedge clk); #1;
      got_lat++;
    end
    if (!out_valid) chk("out_valid_timeout", 32'(out_valid), 32'd1);
    got_res = result; got_z = zero; got_e = err;
  endtask

  // Optionally stall the handshake, checking outputs hold, then complete it.
  task automatic finish_op(input int stall);
    logic [15:0] r0;
    logic z0;
    r0 = result; z0 = zero;
    if (stall > 0) out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_result", 32'(result), 32'(r0));
      chk("stall_zero", 32'(zero), 32'(z0));
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("done_valid_drop", 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [15:0] er;
    logic ez, ee;
    int el, seen;

    vecs[0]  = '{3'd0, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 1};
    vecs[1]  = '{3'd1, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1};
    vecs[2]  = '{3'd4, 16'h0001, 16'h000F, 16'h8000, 1'b0, 1'b0, 16};
    vecs[3]  = '{3'd6, 16'h8001, 16'h0004, 16'h0018, 1'b0, 1'b0, 5};
    vecs[4]  = '{3'd5, 16'h8000, 16'h0000, 16'h8000, 1'b0, 1'b0, 1};
    vecs[5]  = '{3'd3, 16'h0400, 16'h000A, 16'h0001, 1'b0, 1'b0, 1};
    vecs[6]  = '{3'd3, 16'h0400, 16'hFFF9, 16'h0000, 1'b1, 1'b0, 1};
    vecs[7]  = '{3'd7, 16'hFFFF, 16'h1234, 16'h0000, 1'b1, 1'b1, 1};
    vecs[8]  = '{3'd0, 16'hFFFF, 16'h00FF, 16'h00FF, 1'b0, 1'b0, 1};
    vecs[9]  = '{3'd5, 16'hFFFF, 16'h0013, 16'h1FFF, 1'b0, 1'b0, 4};
    vecs[10] = '{3'd6, 16'hC001, 16'h000F, 16'hE000, 1'b0, 1'b0, 16};
    vecs[11] = '{3'd6, 16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0, 1};

    rst = 1'b1; in_valid = 1'b0; op = 3'd0; a = 16'd0; b = 16'd0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Directed table
    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b);
      chk($sformatf("vec%0d_result", i), 32'(got_res), 32'(vecs[i].res));
      chk($sformatf("vec%0d_zero", i), 32'(got_z), 32'(vecs[i].z));
      chk($sformatf("vec%0d_err", i), 32'(got_e), 32'(vecs[i].e));
      chk($sformatf("vec%0d_latency", i), 32'(got_lat), 32'(vecs[i].lat));
      finish_op(0);
    end

    // XOR to zero under 5 cycles of backpressure
    do_op(3'd2, 16'hA5A5, 16'hA5A5);
    chk("xor_result", 32'(got_res), 32'd0);
    chk("xor_zero", 32'(got_z), 32'd1);
    finish_op(5);
    chk("xor_in_ready_after", 32'(in_ready), 32'd1);

    // Make the registered result nonzero so the reset check below is meaningful
    do_op(3'd1, 16'h00F0, 16'h0F00);
    chk("or_result", 32'(got_res), 32'h0FF0);
    finish_op(0);

    // Reset in the middle of a 12-step shift
    in_valid = 1'b1; op = 3'd4; a = 16'h0001; b = 16'h000C;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("shift_in_ready", 32'(in_ready), 32'd0);
    chk("shift_out_valid", 32'(out_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_idle", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("midrst_no_stale", 32'(seen), 32'd0);

    // Randomized ops against the reference model
    for (int i = 0; i < 150; i++) begin
      logic [2:0]  rop;
      logic [15:0] ra, rb;
      rop = 3'($urandom_range(0, 7));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      if (($urandom & 7) == 0) ra = 16'd0;
      model(rop, ra, rb, er, ez, ee, el);
      do_op(rop, ra, rb);
      chk($sformatf("rnd%0d_result op%0d", i, rop), 32'(got_res), 32'(er));
      chk($sformatf("rnd%0d_zero", i), 32'(got_z), 32'(ez));
      chk($sformatf("rnd%0d_err", i), 32'(got_e), 32'(ee));
      chk($sformatf("rnd%0d_latency", i), 32'(got_lat), 32'(el));
      finish_op((($urandom & 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
